fault_sim_sequencer: RTL and testbench
======================================

# fault_sim_sequencer

Sequencer for serial-pass parallel fault simulation of a small combinational circuit-under-test (CUT) with per-site fault-injection controls. One start latches a test vector. The block then runs one fault-free pass and one pass per injected fault, packing each CUT response into a result word. It then flags every fault whose response differs from the fault-free bit. It sits between the test-vector source and the CUT's data and fault-enable inputs, replacing hand-sequenced bench stimulus.

## Interface
- NUM_FAULTS, 3, number of injectable fault sites (≥1)
- NUM_IN, 4, CUT primary-input width
- SETTLE_CYCLES, 1, cycles a configuration is held before sampling (≥1)

- clk  in  1  clock, all state rising-edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- start  in  1  request a run; honoured only in IDLE
- test_vec  in  NUM_IN  vector, latched on accepted start
- cut_out  in  1  CUT response
- cut_in  out  NUM_IN  CUT primary inputs
- fault_sel  out  NUM_FAULTS  one-hot fault enable; bit i activates fault i; all-zero = fault-free
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, results valid
- word  out  NUM_FAULTS+1  raw responses; bit NUM_FAULTS = fault-free, bit i = fault i
- detected  out  NUM_FAULTS  bit i = word[i] XOR word[NUM_FAULTS]
- detect_any  out  1  OR of detected

## Operation
- States: IDLE, SETTLE, SAMPLE, COMPARE.
- IDLE + start: latch test_vec, clear word, set pass = 0, go to SETTLE. Hold detected and detect_any from the previous run.
- Pass p = 0 is fault-free: fault_sel = 0. Pass p = 1..NUM_FAULTS: fault_sel = one-hot bit p−1.
- cut_in = latched vector throughout busy. Changes to test_vec while busy are ignored.
- SETTLE: held SETTLE_CYCLES cycles; settle counter counts down, then go to SAMPLE.
- SAMPLE: one cycle; on its closing edge write cut_out into word at the bit for the current pass.
  - If p < NUM_FAULTS: p++, go to SETTLE.
  - Otherwise go to COMPARE.
- COMPARE: one cycle; on its closing edge load detected and detect_any from word, assert done, go to IDLE.
- start while busy: ignored, no queuing.
- start in the cycle done is high: accepted, since the state is IDLE.
- cut_in and fault_sel return to 0 in IDLE.

## Timing
- Reset values: cut_in = 0, fault_sel = 0, busy = 0, done = 0, word = 0, detected = 0, detect_any = 0; state = IDLE, pass = 0, counter = 0.
- Reset mid-run: immediate return to reset values (asynchronous); the partial run is discarded.
- Start accepted at edge E. busy is high from E until the COMPARE closing edge.
- Each pass lasts SETTLE_CYCLES+1 cycles. fault_sel and cut_in change only at pass boundaries, so they are glitch-free registered outputs.
- done is high for exactly the cycle after edge E + (NUM_FAULTS+1)(SETTLE_CYCLES+1) + 1. Default: 9 cycles.
- word is final from the last SAMPLE edge onward. detected, detect_any and done update on the same edge.
- done and busy are never high together.

## Structure
- Package fault_sim_pkg holds:
  - the state enum
  - a pass-index width constant, clog2(NUM_FAULTS+1)
  - a settle-count width constant
- Sub-module fault_sim_settle_cnt: loadable down-counter with a zero flag, reused by other fault-sim sequencers.
- All other logic stays in the top module.

## Test plan
Bench CUT model: cut_out = XOR of cut_in, inverted when fault_sel[i] && cut_in[i].
- Defaults, test_vec = 4'b1110:
  - word = 4'b1001, detected = 3'b110, detect_any = 1.
  - done exactly 9 cycles after the start edge, for 1 cycle.
- test_vec = 4'b0000: word = 4'b0000, detected = 3'b000, detect_any = 0.
- Sequence monitor, defaults:
  - fault_sel steps 000, 001, 010, 100, each held exactly 2 cycles.
  - cut_in constant at the latched vector; both return to 0 after COMPARE.
- Robustness: start pulsed mid-run, and test_vec changed to 4'b0001 mid-run → no restart, results match the originally latched 4'b1110.
- rst asserted during pass 2:
  - All outputs reset immediately.
  - The following start runs the full 9 cycles and gives correct results.
- SETTLE_CYCLES = 3:
  - done at 17 cycles.
  - start asserted during done → second run begins; detected holds the first run's value until the second COMPARE.

Source files
------------

// File: rtl/fault_sim_pkg.sv
// Shared types and width helpers for the fault-simulation sequencers.
// Width functions let a parameterised instance size its own pass/settle registers.
package fault_sim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    COMPARE
  } state_t;

  localparam int DEF_NUM_FAULTS    = 3;
  localparam int DEF_SETTLE_CYCLES = 1;

  // Pass index runs 0..num_faults (pass 0 is the fault-free reference).
  function automatic int pass_w(input int num_faults);
    return (num_faults >= 1) ? $clog2(num_faults + 1) : 1;
  endfunction

  // Settle counter is loaded with settle_cycles-1 and counts down to zero.
  function automatic int cnt_w(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

  localparam int PASS_W = pass_w(DEF_NUM_FAULTS);
  localparam int CNT_W  = cnt_w(DEF_SETTLE_CYCLES);

endpackage

// File: rtl/fault_sim_settle_cnt.sv
// Loadable down-counter with a zero flag; times how long a CUT configuration
// is held before its response is sampled.
module fault_sim_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fault_sim_sequencer.sv
// Serial-pass fault-simulation sequencer: one fault-free pass plus one pass per
// fault site, packing CUT responses into word and flagging differing faults.
module fault_sim_sequencer
  import fault_sim_pkg::*;
#(
  parameter int NUM_FAULTS    = DEF_NUM_FAULTS,
  parameter int NUM_IN        = 4,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_IN-1:0]     test_vec,
  input  logic                  cut_out,
  output logic [NUM_IN-1:0]     cut_in,
  output logic [NUM_FAULTS-1:0] fault_sel,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_FAULTS:0]   word,
  output logic [NUM_FAULTS-1:0] detected,
  output logic                  detect_any
);

  localparam int PW = pass_w(NUM_FAULTS);
  localparam int CW = cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PASS   = PW'(NUM_FAULTS);

  state_t                  state, state_next;
  logic [PW-1:0]           pass;
  logic [PW-1:0]           word_idx;
  logic [NUM_FAULTS-1:0]   diff;
  logic                    accept;
  logic                    cnt_load;
  logic                    cnt_zero;

  assign accept   = (state == IDLE) && start;
  assign cnt_load = accept || ((state == SAMPLE) && (pass != LAST_PASS));
  // Fault-free response lives in the top bit; fault i's response in bit i.
  assign word_idx = (pass == '0) ? LAST_PASS : pass - 1'b1;
  assign diff     = word[NUM_FAULTS-1:0] ^ {NUM_FAULTS{word[NUM_FAULTS]}};

  fault_sim_settle_cnt #(.W(CW)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (state == SETTLE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt_zero) state_next = SAMPLE;
      SAMPLE:  state_next = (pass == LAST_PASS) ? COMPARE : SETTLE;
      COMPARE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass       <= '0;
      cut_in     <= '0;
      fault_sel  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word       <= '0;
      detected   <= '0;
      detect_any <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cut_in    <= test_vec;
            fault_sel <= '0;
            word      <= '0;
            pass      <= '0;
            busy      <= 1'b1;
          end
        end
        SAMPLE: begin
          word[word_idx] <= cut_out;
          // Next pass enables fault site `pass`; after the last pass the CUT runs fault-free.
          if (pass != LAST_PASS) begin
            pass      <= pass + 1'b1;
            fault_sel <= NUM_FAULTS'(1) << pass;
          end else begin
            fault_sel <= '0;
          end
        end
        COMPARE: begin
          detected   <= diff;
          detect_any <= |diff;
          done       <= 1'b1;
          busy       <= 1'b0;
          cut_in     <= '0;
          pass       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Self-checking bench: XOR CUT with per-input fault inversion, cycle-exact
// sequence monitor, and a behavioural response model.
module tb_fault_sim_sequencer;

  localparam int NF = 3;
  localparam int NI = 4;
  localparam int S1 = 1;
  localparam int S3 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start3;
  logic [NI-1:0] test_vec, test_vec3;
  logic          cut_out, cut_out3;
  logic [NI-1:0] cut_in, cut_in3;
  logic [NF-1:0] fault_sel, fault_sel3;
  logic          busy, busy3, done, done3;
  logic [NF:0]   word, word3;
  logic [NF-1:0] detected, detected3;
  logic          detect_any, detect_any3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // CUT: XOR of inputs, inverted when an enabled fault site sees a 1.
  assign cut_out  = (^cut_in)  ^ (|(fault_sel  & cut_in[NF-1:0]));
  assign cut_out3 = (^cut_in3) ^ (|(fault_sel3 & cut_in3[NF-1:0]));

  fault_sim_sequencer #(.NUM_FAULTS(NF), .NUM_IN(NI), .SETTLE_CYCLES(S1)) dut (
    .clk(clk), .rst(rst), .start(start), .test_vec(test_vec), .cut_out(cut_out),
    .cut_in(cut_in), .fault_sel(fault_sel), .busy(busy), .done(done),
    .word(word), .detected(detected), .detect_any(detect_any)
  );

  fault_sim_sequencer #(.NUM_FAULTS(NF), .NUM_IN(NI), .SETTLE_CYCLES(S3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .test_vec(test_vec3), .cut_out(cut_out3),
    .cut_in(cut_in3), .fault_sel(fault_sel3), .busy(busy3), .done(done3),
    .word(word3), .detected(detected3), .detect_any(detect_any3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: fault-free response is parity; fault i flips it iff v[i] is 1.
  function automatic logic [NF:0] model_word(input logic [NI-1:0] v);
    logic [NF:0] w;
    w[NF] = ^v;
    for (int i = 0; i < NF; i++) w[i] = (^v) ^ v[i];
    return w;
  endfunction

  function automatic logic [NF-1:0] model_det(input logic [NI-1:0] v);
    logic [NF:0]   w;
    logic [NF-1:0] d;
    w = model_word(v);
    for (int i = 0; i < NF; i++) d[i] = (w[i] != w[NF]);
    return d;
  endfunction

  function automatic logic [NF-1:0] exp_sel(input int k, input int s);
    int p;
    p = (k - 1) / (s + 1);
    return (p == 0) ? '0 : NF'(1) << (p - 1);
  endfunction

  // Full run on the default DUT with a per-cycle monitor; optional mid-run disturbance.
  task automatic run1(input logic [NI-1:0] vec, input bit disturb);
    int total;
    total = (NF + 1) * (S1 + 1);
    @(negedge clk);
    test_vec = vec;
    start    = 1'b1;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
      check("cut_in", 32'(cut_in), 32'(vec));
      check("fault_sel", 32'(fault_sel), (k <= total) ? 32'(exp_sel(k, S1)) : 32'd0);
      if (disturb && k == 3) begin
        start    = 1'b1;
        test_vec = 4'b0001;
      end
    end
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("word", 32'(word), 32'(model_word(vec)));
    check("detected", 32'(detected), 32'(model_det(vec)));
    check("detect_any", 32'(detect_any), 32'(|model_det(vec)));
    check("cut_in_idle", 32'(cut_in), 32'd0);
    check("fault_sel_idle", 32'(fault_sel), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cut_in"}, 32'(cut_in), 32'd0);
    check({tag, "_fault_sel"}, 32'(fault_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_word"}, 32'(word), 32'd0);
    check({tag, "_detected"}, 32'(detected), 32'd0);
    check({tag, "_detect_any"}, 32'(detect_any), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NF-1:0] det_prev;
    logic [NI-1:0] rv;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; test_vec = '0; test_vec3 = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    run1(4'b1110, 1'b0);
    run1(4'b0000, 1'b0);
    run1(4'b1110, 1'b1);

    // Reset during pass 2: outputs clear asynchronously, then a clean rerun.
    @(negedge clk);
    test_vec = 4'b1110;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pass2_sel", 32'(fault_sel), 32'b010);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    run1(4'b1110, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rv = NI'($urandom_range(0, (1 << NI) - 1));
      run1(rv, bit'($urandom_range(0, 1)));
    end

    // Longer settle time, back-to-back run started during done.
    @(negedge clk);
    test_vec3 = 4'b1110;
    start3    = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      check("s3_done_low", 32'(done3), 32'd0);
      check("s3_sel", 32'(fault_sel3), (k <= 16) ? 32'(exp_sel(k, S3)) : 32'd0);
    end
    @(negedge clk);
    check("s3_done", 32'(done3), 32'd1);
    check("s3_word", 32'(word3), 32'(model_word(4'b1110)));
    check("s3_detected", 32'(detected3), 32'(model_det(4'b1110)));
    det_prev  = detected3;
    test_vec3 = 4'b0101;
    start3    = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      check("s3b_busy", 32'(busy3), 32'd1);
      check("s3b_hold", 32'(detected3), 32'(model_det(4'b1110)));
    end
    @(negedge clk);
    check("s3b_done", 32'(done3), 32'd1);
    check("s3b_word", 32'(word3), 32'(model_word(4'b0101)));
    check("s3b_detected", 32'(detected3), 32'(model_det(4'b0101)));
    check("s3b_detect_any", 32'(detect_any3), 32'(|model_det(4'b0101)));
    check("s3b_changed", 32'(detected3 != det_prev), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
